branch_predictor_unit: RTL and testbench

//  Dynamic branch predictor in the FETCH stage: direct-mapped BHT of 2-bit saturating counters plus tagged BTB.

---
 rtl/branch_predictor_unit.sv | 152 +++++++++++++++
 tb/tb_branch_predictor_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - FETCH-stage dynamic branch predictor (2-bit BHT + tagged BTB)
//
// Purpose:
//   Direct-mapped table of 2-bit saturating counters (BHT) and a tagged
//   branch target buffer (BTB). The lookup is combinational on PC_curr so the
//   fetch PC mux can use it in the same cycle. Updates arrive from DECODE
//   when a branch resolves. Also keeps two saturating debug counters:
//   total branch updates and mispredicted updates.
//
// Ports:
//   clk               in   1   clock, all state updates on posedge
//   rst_n             in   1   synchronous active-low reset
//   PC_curr           in   16  lookup address (instruction being fetched)
//   IF_ID_PC_curr     in   16  update address (branch resolving in DECODE)
//   IF_ID_prediction  in   2   counter value read when that branch was fetched
//   actual_taken      in   1   resolved direction
//   actual_target     in   16  resolved target
//   wen_BHT           in   1   write counter at IF_ID_PC_curr index
//   wen_BTB           in   1   write target/tag/valid at IF_ID_PC_curr index
//   mispredicted      in   1   counted in mispredict_count when wen_BHT is set
//   prediction        out  2   counter at PC_curr index, 00 on miss
//   predicted_taken   out  1   hit & prediction[1]
//   predicted_target  out  16  BTB target on hit, 0x0000 on miss
//   hit               out  1   entry valid and tag matches PC_curr
//   branch_count      out  16  saturating count of wen_BHT updates
//   mispredict_count  out  16  saturating count of wen_BHT & mispredicted

module branch_predictor_unit #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic [1:0]  IF_ID_prediction,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  input  logic        wen_BHT,
  input  logic        wen_BTB,
  input  logic        mispredicted,
  output logic [1:0]  prediction,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  output logic        hit,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int TAG_BITS = 15 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  // Table storage, flops only.
  logic                valid_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_q     [ENTRIES];
  logic [15:0]         target_q  [ENTRIES];
  logic [1:0]          counter_q [ENTRIES];

  // Address split. PC[0] is never used: instructions are halfword aligned.
  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;

  assign rd_idx = PC_curr[INDEX_BITS:1];
  assign rd_tag = PC_curr[15:INDEX_BITS+1];
  assign wr_idx = IF_ID_PC_curr[INDEX_BITS:1];
  assign wr_tag = IF_ID_PC_curr[15:INDEX_BITS+1];

  logic unused_pc_lsb;
  assign unused_pc_lsb = PC_curr[0] ^ IF_ID_PC_curr[0];

  // Next counter value is derived from the counter that travelled down the
  // pipeline with the branch, not from a fresh table read.
  logic [1:0] next_counter;

  always_comb begin
    next_counter = IF_ID_prediction;
    if (actual_taken) begin
      if (IF_ID_prediction != 2'b11) begin
        next_counter = IF_ID_prediction + 2'b01;
      end
    end else begin
      if (IF_ID_prediction != 2'b00) begin
        next_counter = IF_ID_prediction - 2'b01;
      end
    end
  end

  // Lookup: no bypass from the write port, so a same-cycle update to the
  // looked-up entry becomes visible only after the clock edge.
  logic        rd_valid;
  logic [1:0]  rd_counter;
  logic [15:0] rd_target;
  logic        rd_tag_match;

  always_comb begin
    rd_valid     = valid_q[rd_idx];
    rd_counter   = counter_q[rd_idx];
    rd_target    = target_q[rd_idx];
    rd_tag_match = (tag_q[rd_idx] == rd_tag);
  end

  always_comb begin
    hit              = rd_valid && rd_tag_match;
    prediction       = hit ? rd_counter : 2'b00;
    predicted_target = hit ? rd_target : 16'h0000;
    predicted_taken  = hit && rd_counter[1];
  end

  // BTB: target, tag and valid are written only by wen_BTB, so a counter
  // write to an aliased entry leaves ownership unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 16'h0000;
      end
    end else if (wen_BTB) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= actual_target;
    end
  end

  // BHT counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counter_q[i] <= 2'b00;
      end
    end else if (wen_BHT) begin
      counter_q[wr_idx] <= next_counter;
    end
  end

  // Debug statistics, both hold at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else if (wen_BHT) begin
      if (branch_count != 16'hFFFF) begin
        branch_count <= branch_count + 16'h0001;
      end
      if (mispredicted && (mispredict_count != 16'hFFFF)) begin
        mispredict_count <= mispredict_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb/tb_branch_predictor_unit.sv - directed self-checking bench for branch_predictor_unit

module tb_branch_predictor_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] PC_curr;
  logic [15:0] IF_ID_PC_curr;
  logic [1:0]  IF_ID_prediction;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        wen_BHT;
  logic        wen_BTB;
  logic        mispredicted;
  logic [1:0]  prediction;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        hit;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predictor_unit #(.INDEX_BITS(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC_curr          (PC_curr),
    .IF_ID_PC_curr    (IF_ID_PC_curr),
    .IF_ID_prediction (IF_ID_prediction),
    .actual_taken     (actual_taken),
    .actual_target    (actual_target),
    .wen_BHT          (wen_BHT),
    .wen_BTB          (wen_BTB),
    .mispredicted     (mispredicted),
    .prediction       (prediction),
    .predicted_taken  (predicted_taken),
    .predicted_target (predicted_target),
    .hit              (hit),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [15:0] pc, input logic exp_hit,
                        input logic [1:0] exp_pred, input logic [15:0] exp_tgt);
    PC_curr = pc;
    #1;
    check({tag, ".hit"}, {31'd0, hit}, {31'd0, exp_hit});
    check({tag, ".prediction"}, {30'd0, prediction}, {30'd0, exp_pred});
    check({tag, ".taken"}, {31'd0, predicted_taken}, {31'd0, exp_hit & exp_pred[1]});
    check({tag, ".target"}, {16'd0, predicted_target}, {16'd0, exp_tgt});
  endtask

  task automatic set_update(input logic [15:0] pc, input logic [1:0] pred, input logic taken,
                            input logic [15:0] tgt, input logic wbht, input logic wbtb,
                            input logic misp);
    IF_ID_PC_curr    = pc;
    IF_ID_prediction = pred;
    actual_taken     = taken;
    actual_target    = tgt;
    wen_BHT          = wbht;
    wen_BTB          = wbtb;
    mispredicted     = misp;
  endtask

  task automatic idle();
    wen_BHT      = 1'b0;
    wen_BTB      = 1'b0;
    mispredicted = 1'b0;
  endtask

  task automatic check_stats(input string tag, input logic [15:0] exp_b, input logic [15:0] exp_m);
    check({tag, ".branch_count"}, {16'd0, branch_count}, {16'd0, exp_b});
    check({tag, ".mispredict_count"}, {16'd0, mispredict_count}, {16'd0, exp_m});
  endtask

  initial begin
    rst_n = 1'b0;
    PC_curr = 16'h0000;
    set_update(16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    lookup("reset", 16'h0004, 1'b0, 2'b00, 16'h0000);
    check_stats("reset", 16'd0, 16'd0);

    // Basic update: 01 taken -> 10, BTB allocated
    set_update(16'h0004, 2'b01, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    lookup("update", 16'h0004, 1'b1, 2'b10, 16'h0020);
    check_stats("update", 16'd1, 16'd0);

    // Saturation high: 11 taken stays 11
    set_update(16'h0004, 2'b11, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    lookup("sat_hi", 16'h0004, 1'b1, 2'b11, 16'h0020);

    // Normal decrement: 10 not taken -> 01
    set_update(16'h0004, 2'b10, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    lookup("dec", 16'h0004, 1'b1, 2'b01, 16'h0020);

    // Saturation low: 00 not taken stays 00
    set_update(16'h0004, 2'b00, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    lookup("sat_lo", 16'h0004, 1'b1, 2'b00, 16'h0020);
    check_stats("sat", 16'd4, 16'd0);

    // Alias: 0x0014 shares index 2 with 0x0004 but has a different tag
    lookup("alias_miss", 16'h0014, 1'b0, 2'b00, 16'h0000);
    set_update(16'h0014, 2'b10, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    lookup("alias_new", 16'h0014, 1'b1, 2'b11, 16'h0040);
    lookup("alias_old", 16'h0004, 1'b0, 2'b00, 16'h0000);

    // Same-cycle lookup and update: lookup sees pre-update contents
    PC_curr = 16'h0014;
    set_update(16'h0004, 2'b00, 1'b1, 16'h0030, 1'b1, 1'b1, 1'b0);
    lookup("same_cyc_old", 16'h0014, 1'b1, 2'b11, 16'h0040);
    tick();
    idle();
    lookup("same_cyc_gone", 16'h0014, 1'b0, 2'b00, 16'h0000);
    lookup("same_cyc_new", 16'h0004, 1'b1, 2'b01, 16'h0030);

    // Counter write from an aliased PC leaves the owning tag in place
    set_update(16'h0014, 2'b01, 1'b1, 16'h0050, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    lookup("bht_only", 16'h0004, 1'b1, 2'b10, 16'h0030);
    check_stats("pre_reset", 16'd7, 16'd0);

    // Reset coincident with writes: reset wins
    rst_n = 1'b0;
    set_update(16'h0008, 2'b01, 1'b1, 16'h0060, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    rst_n = 1'b1;
    lookup("rst_wr", 16'h0008, 1'b0, 2'b00, 16'h0000);
    lookup("rst_old", 16'h0004, 1'b0, 2'b00, 16'h0000);
    check_stats("rst_wr", 16'd0, 16'd0);

    // Stats: 3 updates, 2 mispredicted
    set_update(16'h0008, 2'b01, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    mispredicted = 1'b0;
    tick();
    mispredicted = 1'b1;
    tick();
    idle();
    check_stats("stats3", 16'd3, 16'd2);

    // mispredicted alone is ignored
    mispredicted = 1'b1;
    tick();
    idle();
    check_stats("misp_only", 16'd3, 16'd2);

    // Drive branch_count exactly to 0xFFFF
    set_update(16'h0008, 2'b01, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    repeat (65532) @(posedge clk);
    #1;
    idle();
    check_stats("near_sat", 16'hFFFF, 16'hFFFE);

    // One more: branch_count holds, mispredict_count reaches 0xFFFF
    wen_BHT = 1'b1;
    mispredicted = 1'b1;
    tick();
    idle();
    check_stats("sat1", 16'hFFFF, 16'hFFFF);

    // Another: both hold
    wen_BHT = 1'b1;
    mispredicted = 1'b1;
    tick();
    idle();
    check_stats("sat2", 16'hFFFF, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
